// File: rtl/ysyx_25040129_wb_sched.sv
// Write-back arbiter (EXU vs LSU, round-robin) and RAW/WAW register scoreboard for RV32E.
// Optional same-cycle forwarding of the committing result: define YSYX_25040129_WB_BYPASS_EN.
module ysyx_25040129_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rd_wen,
  input  logic [4:0]      iss_src1_id,
  input  logic [4:0]      iss_src2_id,
  input  logic            iss_src1_use,
  input  logic            iss_src2_use,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ls_valid,
  output logic            ls_ready,
  input  logic [4:0]      ls_rd,
  input  logic [XLEN-1:0] ls_data,
  output logic [4:0]      rf_rd,
  output logic            rf_reg_write,
  output logic [XLEN-1:0] rf_result,
  output logic [NREG-1:0] busy_vec
`ifdef YSYX_25040129_WB_BYPASS_EN
  ,
  output logic            fwd_src1_en,
  output logic            fwd_src2_en,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int IW = $clog2(NREG);

  logic [NREG-1:0] busy_q, busy_d;
  logic            last_ls_q, last_ls_d;

  logic            gnt_ex, gnt_ls, gnt_any;
  logic [4:0]      cm_rd;
  logic [XLEN-1:0] cm_data;
  logic [IW-1:0]   cm_idx;
  logic            cm_we;

  logic [IW-1:0]   iss_idx, src1_idx, src2_idx;
  logic [NREG-1:0] clr_vec, rsv_vec, haz_vec;
  logic            src1_haz, src2_haz, waw_haz, reserve;

  // Bit 4 of every register index is architecturally meaningless in RV32E.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{iss_rd[4], iss_src1_id[4], iss_src2_id[4]};

  // Both valid: the requester not granted last wins; outputs are held low during reset.
  always_comb begin
    gnt_ex  = rst & ex_valid & (~ls_valid | last_ls_q);
    gnt_ls  = rst & ls_valid & (~ex_valid | ~last_ls_q);
    gnt_any = gnt_ex | gnt_ls;
  end

  always_comb begin
    cm_rd   = '0;
    cm_data = '0;
    if (gnt_ex) begin
      cm_rd   = ex_rd;
      cm_data = ex_data;
    end else if (gnt_ls) begin
      cm_rd   = ls_rd;
      cm_data = ls_data;
    end
  end

  assign cm_idx = cm_rd[IW-1:0];
  assign cm_we  = gnt_any & (cm_idx != '0);

  always_comb begin
    last_ls_d = last_ls_q;
    if (gnt_ls) begin
      last_ls_d = 1'b1;
    end else if (gnt_ex) begin
      last_ls_d = 1'b0;
    end
  end

  assign iss_idx  = iss_rd[IW-1:0];
  assign src1_idx = iss_src1_id[IW-1:0];
  assign src2_idx = iss_src2_id[IW-1:0];

  // Per-register clear/reserve decode; reserve overrides a same-edge clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      assign clr_vec[gi] = cm_we & (cm_idx == IW'(gi));
      assign rsv_vec[gi] = reserve & (iss_idx == IW'(gi));
      assign busy_d[gi]  = rsv_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
`ifdef YSYX_25040129_WB_BYPASS_EN
      assign haz_vec[gi] = busy_q[gi] & ~clr_vec[gi];
`else
      assign haz_vec[gi] = busy_q[gi];
`endif
    end
  endgenerate

  always_comb begin
    src1_haz  = iss_src1_use & haz_vec[src1_idx];
    src2_haz  = iss_src2_use & haz_vec[src2_idx];
    waw_haz   = iss_rd_wen & haz_vec[iss_idx];
    iss_ready = rst & ~(src1_haz | src2_haz | waw_haz);
    reserve   = iss_valid & iss_ready & iss_rd_wen & (iss_idx != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      last_ls_q <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      last_ls_q <= last_ls_d;
    end
  end

  assign ex_ready     = gnt_ex;
  assign ls_ready     = gnt_ls;
  assign rf_rd        = cm_rd;
  assign rf_reg_write = cm_we;
  assign rf_result    = cm_data;
  assign busy_vec     = busy_q;

`ifdef YSYX_25040129_WB_BYPASS_EN
  assign fwd_src1_en = iss_src1_use & cm_we & (src1_idx == cm_idx);
  assign fwd_src2_en = iss_src2_use & cm_we & (src2_idx == cm_idx);
  assign fwd_data    = cm_data;
`endif

endmodule

// File: tb/tb_ysyx_25040129_wb_sched.sv
// Self-checking bench for ysyx_25040129_wb_sched: directed pins plus randomized traffic vs. a reference model.
module tb_ysyx_25040129_wb_sched;
  localparam int XLEN = 32;
  localparam int NREG = 16;
`ifdef YSYX_25040129_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_ready, iss_rd_wen, iss_src1_use, iss_src2_use;
  logic [4:0]      iss_rd, iss_src1_id, iss_src2_id;
  logic            ex_valid, ex_ready, ls_valid, ls_ready;
  logic [4:0]      ex_rd, ls_rd, rf_rd;
  logic [XLEN-1:0] ex_data, ls_data, rf_result;
  logic            rf_reg_write;
  logic [NREG-1:0] busy_vec;
`ifdef YSYX_25040129_WB_BYPASS_EN
  logic            fwd_src1_en, fwd_src2_en;
  logic [XLEN-1:0] fwd_data;
`endif

  ysyx_25040129_wb_sched #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
    .iss_src1_id(iss_src1_id), .iss_src2_id(iss_src2_id),
    .iss_src1_use(iss_src1_use), .iss_src2_use(iss_src2_use),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rd(ls_rd), .ls_data(ls_data),
    .rf_rd(rf_rd), .rf_reg_write(rf_reg_write), .rf_result(rf_result),
    .busy_vec(busy_vec)
`ifdef YSYX_25040129_WB_BYPASS_EN
    , .fwd_src1_en(fwd_src1_en), .fwd_src2_en(fwd_src2_en), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: set of in-flight destinations plus "who won last".
  bit m_busy[NREG];
  bit nx_busy[NREG];
  bit m_ls_last = 1'b1;
  bit nx_ls_last = 1'b1;
  bit exp_gnt_ex, exp_gnt_ls;

  function automatic bit blocked(input logic [4:0] idx, input logic u, input bit cwe, input logic [4:0] crd);
    return u && m_busy[idx[3:0]] && !(BYP && cwe && crd[3:0] == idx[3:0]);
  endfunction

  initial begin : cmp_proc
    bit e_gex, e_gls, e_we, e_ir, e_f1, e_f2;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [15:0] e_bv;
    forever begin
      @(negedge clk);
      e_gex = 0; e_gls = 0; e_we = 0; e_ir = 0; e_f1 = 0; e_f2 = 0;
      e_rd = '0; e_data = '0; e_bv = '0;
      if (!rst) begin
        for (int i = 0; i < NREG; i++) nx_busy[i] = 1'b0;
        nx_ls_last = 1'b1;
      end else begin
        if (ex_valid && ls_valid) e_gex = m_ls_last;
        else e_gex = ex_valid;
        e_gls = ls_valid && !e_gex;
        if (e_gex) begin e_rd = ex_rd; e_data = ex_data; end
        else if (e_gls) begin e_rd = ls_rd; e_data = ls_data; end
        e_we = (e_gex || e_gls) && (e_rd[3:0] != 4'd0);
        e_ir = !(blocked(iss_src1_id, iss_src1_use, e_we, e_rd) ||
                 blocked(iss_src2_id, iss_src2_use, e_we, e_rd) ||
                 blocked(iss_rd, iss_rd_wen, e_we, e_rd));
        e_f1 = BYP && iss_src1_use && e_we && (iss_src1_id[3:0] == e_rd[3:0]);
        e_f2 = BYP && iss_src2_use && e_we && (iss_src2_id[3:0] == e_rd[3:0]);
        for (int i = 0; i < NREG; i++) begin
          e_bv[i] = m_busy[i];
          nx_busy[i] = m_busy[i];
        end
        if (e_we) nx_busy[e_rd[3:0]] = 1'b0;
        if (iss_valid && e_ir && iss_rd_wen && iss_rd[3:0] != 4'd0) nx_busy[iss_rd[3:0]] = 1'b1;
        nx_ls_last = e_gls ? 1'b1 : (e_gex ? 1'b0 : m_ls_last);
      end
      exp_gnt_ex = e_gex;
      exp_gnt_ls = e_gls;
      chk("ex_ready", ex_ready, e_gex);
      chk("ls_ready", ls_ready, e_gls);
      chk("rf_reg_write", rf_reg_write, e_we);
      chk("rf_rd", rf_rd, e_rd);
      chk("rf_result", rf_result, e_data);
      chk("iss_ready", iss_ready, e_ir);
      chk("busy_vec", busy_vec, e_bv);
`ifdef YSYX_25040129_WB_BYPASS_EN
      chk("fwd_src1_en", fwd_src1_en, e_f1);
      chk("fwd_src2_en", fwd_src2_en, e_f2);
      chk("fwd_data", fwd_data, e_data);
`endif
    end
  end

  initial begin : model_upd
    forever begin
      @(posedge clk);
      for (int i = 0; i < NREG; i++) m_busy[i] = rst ? nx_busy[i] : 1'b0;
      m_ls_last = rst ? nx_ls_last : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 9) < 6) begin
      for (int t = 0; t < 8; t++) begin
        int k;
        k = $urandom_range(1, 15);
        if (m_busy[k]) return 5'(k);
      end
    end
    return r;
  endfunction

  initial begin : main
    bit ex_pend, ls_pend;
    rst = 1'b0;
    iss_valid = 0; iss_rd = 0; iss_rd_wen = 0; iss_src1_id = 0; iss_src2_id = 0;
    iss_src1_use = 0; iss_src2_use = 0;
    ex_valid = 1; ex_rd = 5'd3; ex_data = 32'h1111_2222;
    ls_valid = 1; ls_rd = 5'd4; ls_data = 32'h3333_4444;

    // Held in reset with requests pending: everything low.
    look();
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_ls_ready", ls_ready, 0);
    chk("rst_rf_reg_write", rf_reg_write, 0);
    chk("rst_rf_result", rf_result, 0);
    chk("rst_iss_ready", iss_ready, 0);
    step();
    rst = 1'b1; ex_valid = 0; ls_valid = 0;

    // Issue rd=5, commit 3 cycles later with a dependent reader present.
    iss_valid = 1; iss_rd = 5'd5; iss_rd_wen = 1;
    look(); chk("t1_issue_ready", iss_ready, 1);
    step();
    iss_valid = 0; iss_rd_wen = 0;
    repeat (3) begin
      look(); chk("t1_busy5", busy_vec, 32'h0020);
      step();
    end
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'h1234;
    iss_valid = 1; iss_src1_id = 5'd5; iss_src1_use = 1;
    look();
    chk("t1_ex_ready", ex_ready, 1);
    chk("t1_rf_we", rf_reg_write, 1);
    chk("t1_rf_rd", rf_rd, 5);
    chk("t1_rf_result", rf_result, 32'h1234);
    chk("t1_raw_ready", iss_ready, BYP);
`ifdef YSYX_25040129_WB_BYPASS_EN
    chk("t1_fwd_en", fwd_src1_en, 1);
    chk("t1_fwd_data", fwd_data, 32'h1234);
`endif
    step();
    ex_valid = 0;
    look();
    chk("t1_busy_clear", busy_vec, 0);
    chk("t1_ready_after", iss_ready, 1);
    step();
    iss_valid = 0; iss_src1_use = 0;

    // Reset asserted mid-cycle with busy[2], busy[9] and an EXU request.
    iss_valid = 1; iss_rd = 5'd2; iss_rd_wen = 1;
    step();
    iss_rd = 5'd9;
    step();
    iss_valid = 0; iss_rd_wen = 0;
    ex_valid = 1; ex_rd = 5'd2; ex_data = 32'hDEAD_BEEF;
    #2;
    chk("t6_busy_pre", busy_vec, 32'h0204);
    chk("t6_ex_ready_pre", ex_ready, 1);
    rst = 1'b0;
    #1;
    chk("t6_ex_ready", ex_ready, 0);
    chk("t6_rf_we", rf_reg_write, 0);
    chk("t6_rf_rd", rf_rd, 0);
    chk("t6_rf_result", rf_result, 0);
    chk("t6_busy", busy_vec, 0);
    step();
    rst = 1'b1;

    // Both requesters valid for 4 cycles: EXU first after reset, then alternate.
    ex_valid = 1; ex_rd = 5'd3; ex_data = 32'hAAAA_0003;
    ls_valid = 1; ls_rd = 5'd4; ls_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("t3_ex_ready", ex_ready, (i % 2 == 0));
      chk("t3_ls_ready", ls_ready, (i % 2 == 1));
      chk("t3_rf_we", rf_reg_write, 1);
      chk("t3_rf_rd", rf_rd, (i % 2 == 0) ? 3 : 4);
      chk("t3_busy", busy_vec, 0);
      step();
    end
    ex_valid = 0; ls_valid = 0;

    // LSU write-back to x0 is accepted and discarded.
    iss_valid = 1; iss_rd = 5'd6; iss_rd_wen = 1;
    step();
    iss_valid = 0; iss_rd_wen = 0;
    ls_valid = 1; ls_rd = 5'd0; ls_data = 32'hFFFF_FFFF;
    look();
    chk("t4_ls_ready", ls_ready, 1);
    chk("t4_rf_we", rf_reg_write, 0);
    step();
    ls_valid = 0;
    look(); chk("t4_busy", busy_vec, 32'h0040);
    step();
    ls_valid = 1; ls_rd = 5'd6;
    step();
    ls_valid = 0;

    // Reserve and commit of rd=7 on the same edge.
    iss_valid = 1; iss_rd = 5'd7; iss_rd_wen = 1;
    step();
    ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h77;
    look(); chk("t5_waw_ready", iss_ready, BYP);
    step();
    ex_valid = 0; iss_valid = 0; iss_rd_wen = 0;
    look(); chk("t5_busy_after", busy_vec, BYP ? 32'h0080 : 32'h0);
    step();
    ex_valid = 1;
    step();
    ex_valid = 1; iss_valid = 1; iss_rd_wen = 1;
    look(); chk("t5b_ready", iss_ready, 1);
    step();
    ex_valid = 0; iss_valid = 0; iss_rd_wen = 0;
    look(); chk("t5b_busy", busy_vec, 32'h0080);
    step();

    // Randomized traffic; requesters hold their request until granted.
    ex_pend = 0; ls_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      if (ex_pend && exp_gnt_ex) ex_pend = 0;
      if (ls_pend && exp_gnt_ls) ls_pend = 0;
      if (!ex_pend && $urandom_range(0, 2) != 0) begin
        ex_pend = 1; ex_rd = pick_rd(); ex_data = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1; ls_rd = pick_rd(); ls_data = $urandom;
      end
      ex_valid = ex_pend;
      ls_valid = ls_pend;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = pick_rd();
      iss_rd_wen = 1'($urandom_range(0, 1));
      iss_src1_id = pick_rd();
      iss_src2_id = pick_rd();
      iss_src1_use = 1'($urandom_range(0, 1));
      iss_src2_use = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b1;
    ex_valid = 0; ls_valid = 0; iss_valid = 0;
    look();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_wb_sched.md
# ysyx_25040129_wb_sched

Write-back scheduler and register scoreboard for the RV32E register file. Arbitrates the single register-file write port between the EXU result path and the LSU load-return path, and tracks which architectural registers have a write in flight so the issue stage stalls on RAW/WAW hazards. Sits between IDU/EXU/LSU and the 16-entry register file, driving its `rd`/`reg_write`/`result` inputs.

## Interface
- `XLEN`, 32, data width of results.
- `NREG`, 16, architectural registers tracked; index is `rd[3:0]`, `rd[4]` ignored.
- `clk` input 1 system clock, rising edge.
- `rst` input 1 asynchronous, active-low reset.
- `iss_valid` input 1 issue stage presents an instruction.
- `iss_ready` output 1 instruction may issue this cycle (no hazard).
- `iss_rd` input 5 destination register of issuing instruction.
- `iss_rd_wen` input 1 issuing instruction writes `iss_rd`.
- `iss_src1_id`, `iss_src2_id` input 5 each, source register indices.
- `iss_src1_use`, `iss_src2_use` input 1 each, source actually read.
- `ex_valid` / `ex_ready` input/output 1, EXU write-back handshake.
- `ex_rd` input 5, `ex_data` input XLEN, EXU destination and value.
- `ls_valid` / `ls_ready` input/output 1, LSU write-back handshake.
- `ls_rd` input 5, `ls_data` input XLEN, LSU destination and value.
- `rf_rd` output 5, `rf_reg_write` output 1, `rf_result` output XLEN, register-file write port.
- `busy_vec` output NREG, current scoreboard bits (debug/perf).
- `fwd_src1_en`, `fwd_src2_en` output 1 each, `fwd_data` output XLEN (present only with bypass enabled).

## Operation
- State: `busy[NREG-1:0]`, round-robin pointer `last_ls` (1 = LSU granted last).
- Arbitration: one grant per cycle among valid requesters. Both valid: grant the one not granted last. One valid: grant it. Grant asserts that requester's `*_ready`; pointer updates only on an actual transfer.
- Commit: granted request drives `rf_rd`, `rf_result`; `rf_reg_write` = grant & (rd[3:0] != 0). rd=0 requests are accepted and discarded.
- Hazard: `iss_ready` = 1 unless `busy[src1]&src1_use`, `busy[src2]&src2_use`, or `busy[iss_rd]&iss_rd_wen` (WAW). Index 0 is never busy.
- Reserve: `iss_valid & iss_ready & iss_rd_wen & rd[3:0]!=0` sets `busy[rd]` at next edge.
- Clear: commit of rd≠0 clears `busy[rd]` at next edge.
- Same-edge reserve and clear of same index: reserve wins, bit stays 1.
- Write-back for a register not marked busy is legal; no error, clear is a no-op.
- Requesters must hold `*_valid`, rd, data stable until ready; scheduler does not check this.

## Timing
- Grant and write-port outputs are combinational from `*_valid` and pointer; register file captures at the same rising edge (zero added latency).
- `busy` updates one cycle after reserve/commit; `iss_ready` for a dependent instruction rises the cycle after the producer's commit (without bypass).
- Reset (`rst` low, any time, including mid-handshake): `busy`=0, `last_ls`=1 (EXU wins first tie), `ex_ready`=`ls_ready`=`iss_ready`=0, `rf_reg_write`=0, `rf_rd`=0, `rf_result`=0, `fwd_*`=0. In-flight reservations are dropped.
- After `rst` releases, normal operation from the first rising edge.
- Worst-case wait for a continuously valid requester: 1 cycle.

## Configuration
- `YSYX_25040129_WB_BYPASS_EN`: defined — a source matching the index being committed this cycle is treated as not busy, `fwd_srcN_en`=1 and `fwd_data`=`rf_result`; dependent instruction issues in the producer's commit cycle. WAW on a committing index also permitted (reserve wins). Undefined — no forward ports, strict one-cycle stall after commit.

## Test plan
- Reset then issue `rd=5`, EXU commits `rd=5,data=0x1234` 3 cycles later -> `busy[5]` high for 3 cycles, `rf_reg_write`=1, `rf_rd`=5, `rf_result`=0x1234, `busy[5]`=0 next cycle.
- Issue reading `src1=5` while `busy[5]`=1 -> `iss_ready`=0 until the cycle after commit; with bypass, `iss_ready`=1 and `fwd_src1_en`=1, `fwd_data`=commit value in commit cycle.
- EXU and LSU both valid for 4 cycles (rd=3, rd=4) -> grants alternate EXU, LSU, EXU, LSU; exactly one `rf_reg_write` per cycle.
- LSU commit to `rd=0`, data 0xFFFF_FFFF -> `ls_ready`=1, `rf_reg_write`=0, `busy_vec` unchanged.
- Issue `rd=7` in same cycle as commit of `rd=7` (bypass on) -> `busy[7]` remains 1 afterward.
- Assert `rst` low with `busy[2]`,`busy[9]` set and EXU valid -> all outputs 0 immediately, `busy_vec`=0 after release.
